// File: rtl/fwd_scoreboard_unit.sv
// Forwarding scoreboard: tracks in-flight register writes over DEPTH stages and
// produces per-operand forward selects / stall. Optional stats: FWD_STALL_STATS_EN.
module fwd_scoreboard_unit #(
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned DEPTH   = 3,
  parameter int unsigned LAT_W   = 2,
  parameter int unsigned SEL_W   = $clog2(DEPTH+1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]   id_src,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic                        id_regwrite,
  input  logic [REG_AW-1:0]           id_dst,
  input  logic [LAT_W-1:0]            id_lat,
  input  logic                        pipe_hold,
  input  logic                        flush,
  output logic [NUM_SRC*SEL_W-1:0]    fwd_sel,
  output logic                        stall,
  output logic                        busy
`ifdef FWD_STALL_STATS_EN
  ,
  output logic [31:0]                 stall_cycles,
  output logic [31:0]                 fwd_count
`endif
);

  logic [DEPTH:1]    valid_q, valid_d;
  logic [REG_AW-1:0] dst_q [1:DEPTH];
  logic [REG_AW-1:0] dst_d [1:DEPTH];
  logic [LAT_W-1:0]  cnt_q [1:DEPTH];
  logic [LAT_W-1:0]  cnt_d [1:DEPTH];
  logic              hit_nr;

  // Lookup: the lowest matching stage is the youngest producer and shadows older ones.
  always_comb begin
    logic [REG_AW-1:0] src;
    logic              found;
    fwd_sel = '0;
    hit_nr  = 1'b0;
    src     = '0;
    found   = 1'b0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      src   = id_src[s*REG_AW +: REG_AW];
      found = 1'b0;
      if (id_valid && id_src_used[s] && (src != '0)) begin
        for (int unsigned k = 1; k <= DEPTH; k++) begin
          if (!found && valid_q[k] && (dst_q[k] == src)) begin
            found = 1'b1;
            if (cnt_q[k] == '0) fwd_sel[s*SEL_W +: SEL_W] = SEL_W'(k);
            else                hit_nr = 1'b1;
          end
        end
      end
    end
  end

  assign stall = hit_nr & ~flush;
  assign busy  = |valid_q;

  always_comb begin
    valid_d = valid_q;
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      dst_d[k] = dst_q[k];
      cnt_d[k] = cnt_q[k];
    end
    if (!pipe_hold) begin
      for (int unsigned k = 2; k <= DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        dst_d[k]   = dst_q[k-1];
        cnt_d[k]   = (cnt_q[k-1] == '0) ? '0 : cnt_q[k-1] - LAT_W'(1);
      end
      if (id_valid && id_regwrite && (id_dst != '0) && !stall && !flush) begin
        valid_d[1] = 1'b1;
        dst_d[1]   = id_dst;
        cnt_d[1]   = id_lat;
      end else begin
        valid_d[1] = 1'b0;
        dst_d[1]   = '0;
        cnt_d[1]   = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        dst_q[k] <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned k = 1; k <= DEPTH; k++) begin
        dst_q[k] <= dst_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

`ifdef FWD_STALL_STATS_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] fwd_count_q, fwd_count_d;
  logic [32:0] fwd_sum;
  logic [31:0] nfwd;

  always_comb begin
    nfwd = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++) begin
      if (fwd_sel[s*SEL_W +: SEL_W] != '0) nfwd = nfwd + 32'd1;
    end
    stall_cycles_d = stall_cycles_q;
    fwd_count_d    = fwd_count_q;
    fwd_sum        = {1'b0, fwd_count_q} + {1'b0, nfwd};
    if (stall && !pipe_hold && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + 32'd1;
    if (id_valid && !stall && !pipe_hold && !flush)
      fwd_count_d = fwd_sum[32] ? '1 : fwd_sum[31:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      fwd_count_q    <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      fwd_count_q    <= fwd_count_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_count    = fwd_count_q;
`endif

endmodule
